// File: rtl/mem_dump_reader.sv
// Streams len consecutive memory words, each tagged with its address, onto a valid/ready output stream.
// Define DUMP_CHECKSUM_EN to build the running checksum; otherwise checksum is tied to zero.
module mem_dump_reader #(
    parameter int N          = 32,
    parameter int AW         = 7,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  checksum
);

    // Output handshake: a beat transfers on any edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_valid/out_data/out_addr stay unchanged.

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    localparam logic [AW:0]   REM_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [OW-1:0] OCC_MAX  = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [AW:0]         rem_q, rem_d;
    logic [AW-1:0]       next_addr_q, next_addr_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
    logic [AW-1:0]       pipe_addr_q [RD_LAT];
    logic [AW-1:0]       pipe_addr_d [RD_LAT];
    logic [N-1:0]        fifo_data_q [FIFO_DEPTH];
    logic [N-1:0]        fifo_data_d [FIFO_DEPTH];
    logic [AW-1:0]       fifo_addr_q [FIFO_DEPTH];
    logic [AW-1:0]       fifo_addr_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fifo_count_q, fifo_count_d;

    logic [OW-1:0]       inflight;
    logic [OW-1:0]       occupancy;
    logic                start_acc;
    logic                issue;
    logic                push;
    logic                pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            next_addr_q  <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            pipe_vld_q   <= '0;
            pipe_addr_q  <= '{default: '0};
            fifo_data_q  <= '{default: '0};
            fifo_addr_q  <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            next_addr_q  <= next_addr_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_addr_q  <= pipe_addr_d;
            fifo_data_q  <= fifo_data_d;
            fifo_addr_q  <= fifo_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Outstanding reads: the strobe on the port now plus every tracked entry not yet pushed.
    always_comb begin
        inflight = OW'(mem_rd_en_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OW'(pipe_vld_q[i]);
        end
    end

    assign occupancy = OW'(fifo_count_q) + inflight;
    assign start_acc = (state_q == S_IDLE) && start;
    assign issue     = (state_q == S_ISSUE) && (rem_q != '0) && (occupancy < OCC_MAX);
    assign push      = pipe_vld_q[RD_LAT-1];
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = (len == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  if (issue && rem_q == REM_ONE) state_d = S_DRAIN;
            S_DRAIN:  if (pop && fifo_count_q == CNT_ONE && inflight == '0) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done      = (state_q == S_FINISH);
        mem_rd_en = mem_rd_en_q;
        mem_addr  = mem_addr_q;
        out_valid = (fifo_count_q != '0);
        out_data  = fifo_data_q[rd_ptr_q];
        out_addr  = fifo_addr_q[rd_ptr_q];
    end

    always_comb begin
        rem_d        = rem_q;
        next_addr_d  = next_addr_q;
        mem_rd_en_d  = issue;
        mem_addr_d   = mem_addr_q;
        pipe_vld_d   = pipe_vld_q;
        pipe_addr_d  = pipe_addr_q;
        fifo_data_d  = fifo_data_q;
        fifo_addr_d  = fifo_addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (start_acc) begin
            rem_d       = len;
            next_addr_d = base_addr;
        end
        if (issue) begin
            mem_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_ONE;
            rem_d       = rem_q - REM_ONE;
        end

        pipe_vld_d[0]  = mem_rd_en_q;
        pipe_addr_d[0] = mem_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        // The last pipe stage lines up with mem_rdata being valid on the port.
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_addr_d[wr_ptr_q] = pipe_addr_q[RD_LAT-1];
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CNT_ONE;
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - CNT_ONE;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [N-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_acc) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized bench for mem_dump_reader: a memory array plus an expected-beat queue per dump.
// Two instances: RD_LAT=1/FIFO_DEPTH=4 for most scenarios, RD_LAT=3/FIFO_DEPTH=8 for the long-latency run.
`timescale 1ns/1ps
module tb_mem_dump_reader;

    localparam int N     = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_rdata;
    logic [N-1:0]  out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [N-1:0]  checksum;

    logic          start_3 = 1'b0;
    logic [AW-1:0] base_3 = '0;
    logic [AW:0]   len_3 = '0;
    logic          mem_rd_en_3;
    logic [AW-1:0] mem_addr_3;
    logic [N-1:0]  mem_rdata_3;
    logic [N-1:0]  out_data_3;
    logic [AW-1:0] out_addr_3;
    logic          out_valid_3;
    logic          out_ready_3 = 1'b1;
    logic          busy_3;
    logic          done_3;
    logic [N-1:0]  checksum_3;

    mem_dump_reader #(.N(N), .AW(AW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    mem_dump_reader #(.N(N), .AW(AW), .RD_LAT(3), .FIFO_DEPTH(8)) dut3 (
        .clk(clk), .reset(reset), .start(start_3), .base_addr(base_3), .len(len_3),
        .mem_rd_en(mem_rd_en_3), .mem_addr(mem_addr_3), .mem_rdata(mem_rdata_3),
        .out_data(out_data_3), .out_addr(out_addr_3), .out_valid(out_valid_3), .out_ready(out_ready_3),
        .busy(busy_3), .done(done_3), .checksum(checksum_3)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory models ----------------
    logic [N-1:0] mem_model [128];
    logic [N-1:0] rd1;
    logic [N-1:0] d3 [3];

    always @(posedge clk) begin
        rd1 <= mem_rd_en ? mem_model[mem_addr] : $urandom();
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        d3[0] <= mem_rd_en_3 ? mem_model[mem_addr_3] : $urandom();
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign mem_rdata_3 = d3[2];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- ready driver ----------------
    int ready_mode = 0;
    int ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // ---------------- scoreboard, instance 1 ----------------
    logic [AW+N-1:0] exp_q [$];
    int  first_valid_cyc, last_hs_cyc, done_cyc, hs_cnt, rd_seen;
    bit  done_seen, busy_seen, prev_stall;
    logic [N-1:0] done_cksum;
    int  issued = 0, popped_done = 0, popped_prev = 0;

    always @(negedge clk) begin
        if (reset) begin
            issued = 0; popped_done = 0; popped_prev = 0; prev_stall = 1'b0;
        end else begin
            bit hs;
            hs = out_valid && out_ready;
            if (done) begin
                done_seen = 1'b1; done_cyc = cyc; done_cksum = checksum;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            if (busy) busy_seen = 1'b1;
            if (mem_rd_en) begin
                rd_seen++;
                check("occupancy_below_depth", 64'((issued - popped_prev) < DEPTH), 64'd1);
            end
            if (prev_stall) check("stall_keeps_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("beat_addr", 64'(out_addr), 64'(exp_q[0][AW+N-1:N]));
                    check("beat_data", 64'(out_data), 64'(exp_q[0][N-1:0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (out_ready) begin
                    hs_cnt++;
                    last_hs_cyc = cyc;
                end
            end
            prev_stall  = out_valid && !out_ready;
            popped_prev = popped_done;
            popped_done = popped_done + int'(hs);
            issued      = issued + int'(mem_rd_en);
        end
    end

    // ---------------- scoreboard, instance 3 ----------------
    logic [AW+N-1:0] exp3_q [$];
    int  first_valid3 = -1, first_hs3 = -1, last_hs3 = -1, hs3 = 0;
    bit  done3_seen = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (done_3) done3_seen = 1'b1;
            if (out_valid_3) begin
                if (first_valid3 < 0) first_valid3 = cyc;
                check("beat3_expected", 64'(exp3_q.size() != 0), 64'd1);
                if (exp3_q.size() != 0) begin
                    check("beat3_addr", 64'(out_addr_3), 64'(exp3_q[0][AW+N-1:N]));
                    check("beat3_data", 64'(out_data_3), 64'(exp3_q[0][N-1:0]));
                    if (out_ready_3) void'(exp3_q.pop_front());
                end
                if (out_ready_3) begin
                    if (first_hs3 < 0) first_hs3 = cyc;
                    last_hs3 = cyc;
                    hs3++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        hs_cnt = 0; rd_seen = 0; done_seen = 1'b0; busy_seen = 1'b0;
    endtask

    task automatic do_dump(input logic [AW-1:0] b, input logic [AW:0] n, input int rmode,
                           input bit mid_start, output logic [N-1:0] exp_sum);
        logic [AW-1:0] a;
        int t0;
        exp_sum    = '0;
        ready_mode = rmode;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            exp_q.push_back({a, mem_model[a]});
            exp_sum = exp_sum + mem_model[a];
        end
        clear_stats();
        start = 1'b1; base_addr = b; len = n;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = AW'($urandom()); len = (AW+1)'($urandom());
        if (mid_start) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1; base_addr = b ^ 7'h40; len = 8'd3;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int w = 0; w < 3000 && !done_seen; w++) begin
            @(posedge clk);
            #1;
        end
        check("done_seen", 64'(done_seen), 64'd1);
        check("all_beats_out", 64'(exp_q.size()), 64'd0);
        check("beat_count", 64'(hs_cnt), 64'(n));
        check("read_count", 64'(rd_seen), 64'(n));
        if (n == '0) begin
            check("len0_done_cycle", 64'(done_cyc), 64'(t0));
            check("len0_busy_never", 64'(busy_seen), 64'd0);
        end else begin
            check("first_valid_latency", 64'(first_valid_cyc), 64'(t0 + LAT + 2));
            check("done_after_last_beat", 64'(done_cyc), 64'(last_hs_cyc + 1));
        end
`ifndef DUMP_CHECKSUM_EN
        exp_sum = '0;
`endif
        check("checksum_at_done", 64'(done_cksum), 64'(exp_sum));
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_not_busy", 64'(busy), 64'd0);
        check("checksum_held", 64'(checksum), 64'(exp_sum));
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] s;
        int stray, t3;
        for (int i = 0; i < 128; i++) mem_model[i] = $urandom();
        mem_model[0] = 32'h20010002;
        mem_model[1] = 32'h20020005;
        mem_model[2] = 32'h00221820;
        mem_model[3] = 32'hAC230000;
        mem_model[4] = 32'h8C240000;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_out_valid_3", 64'(out_valid_3), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_dump(7'h00, 8'd5, 0, 1'b0, s);
`ifdef DUMP_CHECKSUM_EN
        check("plan_checksum", 64'(done_cksum), 64'h786C1827);
`endif
        do_dump(7'h00, 8'd5, 1, 1'b0, s);
        do_dump(7'h7E, 8'd4, 0, 1'b0, s);
        do_dump(7'h55, 8'd0, 0, 1'b0, s);
        do_dump(7'h20, 8'd10, 1, 1'b1, s);

        // Reset right after the second beat of a dump.
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) exp_q.push_back({7'h10 + 7'(i), mem_model[7'h10 + 7'(i)]});
        clear_stats();
        start = 1'b1; base_addr = 7'h10; len = 8'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int w = 0; w < 100 && hs_cnt < 2; w++) begin
            @(posedge clk);
            #1;
        end
        check("reached_beat2", 64'(hs_cnt), 64'd2);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            stray += int'(out_valid) + int'(mem_rd_en) + int'(busy) + int'(done);
        end
        check("quiet_after_reset", 64'(stray), 64'd0);
        do_dump(7'h30, 8'd6, 2, 1'b0, s);

        // Randomized dumps, including one full-memory pass.
        for (int k = 0; k < 5; k++) begin
            do_dump(AW'($urandom()), (AW+1)'($urandom_range(1, 40)), 2, 1'b0, s);
        end
        do_dump(AW'($urandom()), 8'd128, 2, 1'b0, s);

        // Long-latency instance: 16 words with out_ready held high.
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) exp3_q.push_back({7'h50 + 7'(i), mem_model[7'h50 + 7'(i)]});
        start_3 = 1'b1; base_3 = 7'h50; len_3 = 8'd16;
        t3 = cyc + 1;
        @(posedge clk);
        #1;
        start_3 = 1'b0;
        for (int w = 0; w < 500 && !done3_seen; w++) begin
            @(posedge clk);
            #1;
        end
        check("lat3_done_seen", 64'(done3_seen), 64'd1);
        check("lat3_first_valid", 64'(first_valid3), 64'(t3 + 5));
        check("lat3_back_to_back", 64'(last_hs3 - first_hs3), 64'd15);
        check("lat3_beat_count", 64'(hs3), 64'd16);
        check("lat3_all_out", 64'(exp3_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
